// File: rtl/desynk_pkg.sv
// Shared types and constants for the desynk glitch-chain blocks.
// Pure declarations; no latency and no flow control.
package desynk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    DONE  = 3'd4
  } trig_seq_state_t;

  localparam int TRIG_SEQ_MIN_SYNC   = 2;
  localparam int TRIG_SEQ_FIRE_CNT_W = 16;

  function automatic logic [TRIG_SEQ_FIRE_CNT_W-1:0] sat_inc16(
    input logic [TRIG_SEQ_FIRE_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + TRIG_SEQ_FIRE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser plus polarity-selected edge detector; edge_o is a registered
// one-cycle flag SYNC_STAGES cycles after capture. No backpressure: edges are never held.
module sync_edge_detect
  import desynk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISING = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  localparam int   STAGES   = (SYNC_STAGES < TRIG_SEQ_MIN_SYNC) ? TRIG_SEQ_MIN_SYNC : SYNC_STAGES;
  localparam logic IDLE_LVL = (EDGE_RISING != 0) ? 1'b0 : 1'b1;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              edge_q;
  logic              edge_d;

  // hist_q trails the last synchroniser stage so each edge yields exactly one flag.
  always_comb begin
    edge_d = 1'b0;
    if (EDGE_RISING != 0) begin
      edge_d = sync_q[STAGES-1] & ~hist_q;
    end else begin
      edge_d = ~sync_q[STAGES-1] & hist_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE_LVL}};
      hist_q <= IDLE_LVL;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/trigger_sequencer.sv
// Arm / wait-for-edge / delay / pulse sequencer; trigger rises edge+1+delay cycles after the flag.
// No backpressure: arm is ignored while busy. Optional fire counter via TRIGGER_SEQUENCER_COUNT_EN.
module trigger_sequencer
  import desynk_pkg::*;
#(
  parameter int DELAY_W     = 16,
  parameter int PULSE_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISING = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic               ext_trigger,
  output logic               trigger,
  output logic               armed,
  output logic               busy,
  output logic               done
`ifdef TRIGGER_SEQUENCER_COUNT_EN
  ,
  output logic [TRIG_SEQ_FIRE_CNT_W-1:0] fire_count
`endif
);

  localparam int CNT_W = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;

  trig_seq_state_t    state_q;
  logic [DELAY_W-1:0] dly_q;
  logic [PULSE_W-1:0] len_q;
  logic [PULSE_W-1:0] len_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   dly_ext;
  logic [CNT_W-1:0]   len_ext;
  logic               cnt_zero;
  logic               edge_flag;
  logic               trigger_q;
  logic               armed_q;
  logic               busy_q;
  logic               done_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_RISING(EDGE_RISING)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ext_trigger),
    .edge_o (edge_flag)
  );

  assign len_d    = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
  assign dly_ext  = CNT_W'(dly_q);
  assign len_ext  = CNT_W'(len_q);
  assign cnt_zero = (cnt_q == '0);

  // Outputs are registered alongside the state so they always describe the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      len_q     <= PULSE_W'(1);
      cnt_q     <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            dly_q   <= delay;
            len_q   <= len_d;
            state_q <= ARMED;
            armed_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (edge_flag) begin
            armed_q <= 1'b0;
            if (dly_q == '0) begin
              state_q   <= PULSE;
              cnt_q     <= len_ext - CNT_W'(1);
              trigger_q <= 1'b1;
            end else begin
              state_q <= DELAY;
              cnt_q   <= dly_ext - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_zero) begin
            state_q   <= PULSE;
            cnt_q     <= len_ext - CNT_W'(1);
            trigger_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_zero) begin
            state_q   <= DONE;
            trigger_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          trigger_q <= 1'b0;
          armed_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign trigger = trigger_q;
  assign armed   = armed_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef TRIGGER_SEQUENCER_COUNT_EN
  logic                           pulse_entry;
  logic [TRIG_SEQ_FIRE_CNT_W-1:0] fire_cnt_q;
  logic [TRIG_SEQ_FIRE_CNT_W-1:0] fire_cnt_d;

  // Mirrors the FSM's PULSE-entry conditions; abort suppresses the entry, so no count.
  assign pulse_entry = !abort &&
                       (((state_q == ARMED) && edge_flag && (dly_q == '0)) ||
                        ((state_q == DELAY) && cnt_zero));
  assign fire_cnt_d  = pulse_entry ? sat_inc16(fire_cnt_q) : fire_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_cnt_q <= '0;
    end else begin
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign fire_count = fire_cnt_q;
`endif

endmodule
